mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port of the multi-cycle processor between two requesters:
//  the control unit's memory access path (cpu) and the program/data loader (ldr) that fills

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the control
// unit (cpu) and the program/data loader (ldr). One transaction at a time runs
// through IDLE -> ISSUE -> WAIT -> DONE. Arbitration favours cpu while RUN is
// high and ldr otherwise, with a consecutive-grant cap so the other side is
// never starved.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,   // 1..15
    parameter int MAX_CONSEC = 4    // >= 1
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          RUN,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic          cpu_stall,

    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_done,

    output logic [DW-1:0] rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_CONSEC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;      // 1: loader owns the transaction
    logic          we_q, we_d;            // latched write flag of the owner
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [3:0]    lat_q, lat_d;
    logic [CW-1:0] consec_q, consec_d;
    logic          run_q, run_d;

    logic          run_changed;
    logic [CW-1:0] consec_eff;
    logic          pick_ldr;

    // Next-state, arbitration and datapath-latch logic.
    always_comb begin
        // NOTE: every variable gets its hold/default value first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        lat_d       = lat_q;
        run_d       = RUN;
        pick_ldr    = 1'b0;

        // A change of favoured side restarts the fairness count.
        run_changed = (RUN != run_q);
        consec_eff  = run_changed ? '0 : consec_q;
        consec_d    = consec_eff;

        case (state_q)
            S_IDLE: begin
                if (cpu_req || ldr_req) begin
                    if (cpu_req && ldr_req) begin
                        if (consec_eff >= CW'(MAX_CONSEC)) begin
                            pick_ldr = RUN;          // cap reached: other side wins
                            consec_d = '0;
                        end else begin
                            pick_ldr = ~RUN;         // favoured side wins
                            consec_d = consec_eff + 1'b1;
                        end
                    end else begin
                        pick_ldr = ldr_req;
                        consec_d = '0;
                    end
                    owner_d     = pick_ldr;
                    we_d        = pick_ldr ? ldr_we    : cpu_we;
                    mem_addr_d  = pick_ldr ? ldr_addr  : cpu_addr;
                    mem_wdata_d = pick_ldr ? ldr_wdata : cpu_wdata;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_d;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lat_d   = 4'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; everything clears on reset, mid-transaction included.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            lat_q       <= 4'd0;
            consec_q    <= '0;
            run_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            lat_q       <= lat_d;
            consec_q    <= consec_d;
            run_q       <= run_d;
        end
    end

    // Grant and done are decoded from the registered state and owner.
    always_comb begin
        cpu_gnt   = (state_q == S_ISSUE) && !owner_q;
        ldr_gnt   = (state_q == S_ISSUE) &&  owner_q;
        cpu_done  = (state_q == S_DONE)  && !owner_q;
        ldr_done  = (state_q == S_DONE)  &&  owner_q;
        cpu_stall = cpu_req && !cpu_done;
    end

    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a MEM_LAT=1 instance exercised by hand
// sequences, a vector table and a completion scoreboard, plus a MEM_LAT=3
// instance for multi-cycle latency timing.
module tb_mem_port_arbiter;

    localparam logic [31:0] GARB = 32'h0BAD_0BAD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        RESET = 1'b1;
    logic        RUN   = 1'b0;

    // MEM_LAT = 1 instance signals
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        ldr_req = 1'b0, ldr_we = 1'b0;
    logic [31:0] ldr_addr = '0, ldr_wdata = '0;
    logic        cpu_gnt, cpu_done, cpu_stall, ldr_gnt, ldr_done;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = GARB;
    logic        mem_en, mem_we;

    // MEM_LAT = 3 instance signals
    logic        c3_req = 1'b0;
    logic [31:0] c3_addr = '0;
    logic        c3_gnt, c3_done, c3_stall, l3_gnt, l3_done;
    logic [31:0] rdata3, mem3_addr, mem3_wdata;
    logic [31:0] mem3_rdata = GARB;
    logic        mem3_en, mem3_we;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_CONSEC(4)) dut (
        .clk(clk), .RESET(RESET), .RUN(RUN),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_done(ldr_done),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_CONSEC(4)) dut3 (
        .clk(clk), .RESET(RESET), .RUN(RUN),
        .cpu_req(c3_req), .cpu_we(1'b0), .cpu_addr(c3_addr), .cpu_wdata(32'h0),
        .cpu_gnt(c3_gnt), .cpu_done(c3_done), .cpu_stall(c3_stall),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0),
        .ldr_gnt(l3_gnt), .ldr_done(l3_done),
        .rdata(rdata3),
        .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
        .mem_rdata(mem3_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model for the MEM_LAT=1 instance: data valid for exactly one
    // cycle, the one after the mem_en cycle; garbage at all other times.
    logic [31:0] mem_arr [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_arr[mem_addr[9:2]] = mem_wdata;
                mem_rdata <= GARB;
            end else begin
                mem_rdata <= mem_arr[mem_addr[9:2]];
            end
        end else begin
            mem_rdata <= GARB;
        end
    end

    // Memory model for the MEM_LAT=3 instance: data valid only in the third
    // cycle after the mem_en cycle.
    logic [2:0] v3 = 3'b000;
    always @(posedge clk) begin
        v3         <= {v3[1:0], mem3_en};
        mem3_rdata <= v3[1] ? 32'hCAFE_0003 : GARB;
    end

    // Completion scoreboard for the MEM_LAT=1 instance.
    typedef struct packed {
        logic        is_ldr;
        logic        is_read;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        if (cpu_done || ldr_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {62'd0, cpu_done, ldr_done}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_owner", 64'(ldr_done), 64'(e.is_ldr));
                check("sb_single_done", 64'(cpu_done & ldr_done), 64'd0);
                if (e.is_read) check("sb_rdata", 64'(rdata), 64'(e.rdata));
            end
        end
    end

    typedef struct {
        logic        run;
        logic        creq;
        logic        cwe;
        logic [31:0] caddr;
        logic [31:0] cwdata;
        logic        lreq;
        logic        lwe;
        logic [31:0] laddr;
        logic [31:0] lwdata;
        logic        exp_ldr;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs [8];

    task automatic drop_all();
        cpu_req = 1'b0;
        ldr_req = 1'b0;
    endtask

    // Waits until the scoreboard drains or the cycle budget runs out.
    task automatic drain(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        drop_all();
        check(name, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        exp_t e;

        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[4] = 32'hDEAD_BEEF;     // address 0x10

        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,          1'b1, 1'b1, 32'h04, 32'h1234,      1'b1, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h04, 32'h0,          1'b0, 1'b0, 32'h00, 32'h0,         1'b0, 32'h1234};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0,          1'b1, 1'b1, 32'h20, 32'hA5A5A5A5,  1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h0,          1'b0, 1'b0, 32'h00, 32'h0,         1'b0, 32'hA5A5A5A5};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0,          1'b1, 1'b1, 32'h30, 32'h77,        1'b0, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h00, 32'h0,          1'b1, 1'b0, 32'h04, 32'h0,         1'b1, 32'h1234};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h11112222,   1'b0, 1'b0, 32'h00, 32'h0,         1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,          1'b1, 1'b0, 32'h10, 32'h0,         1'b1, 32'h11112222};

        // ---- reset state ----
        @(negedge clk);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_gnt", {62'd0, cpu_gnt, ldr_gnt}, 64'd0);
        check("rst_done", {62'd0, cpu_done, ldr_done}, 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);

        // ---- single cpu read, exact timing ----
        RUN = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        sb_q.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF});
        #1 check("t2_stall_N", 64'(cpu_stall), 64'd1);
        @(negedge clk);                                   // N+1
        check("t2_gnt", 64'(cpu_gnt), 64'd1);
        check("t2_ldr_gnt", 64'(ldr_gnt), 64'd0);
        check("t2_mem_en", 64'(mem_en), 64'd1);
        check("t2_mem_we", 64'(mem_we), 64'd0);
        check("t2_mem_addr", 64'(mem_addr), 64'h10);
        check("t2_stall_N1", 64'(cpu_stall), 64'd1);
        @(negedge clk);                                   // N+2
        check("t2_gnt_off", 64'(cpu_gnt), 64'd0);
        check("t2_mem_en_off", 64'(mem_en), 64'd0);
        check("t2_done_early", 64'(cpu_done), 64'd0);
        check("t2_stall_N2", 64'(cpu_stall), 64'd1);
        @(negedge clk);                                   // N+3
        #1;
        check("t2_done", 64'(cpu_done), 64'd1);
        check("t2_stall_done", 64'(cpu_stall), 64'd0);
        check("t2_rdata", 64'(rdata), 64'hDEAD_BEEF);
        drop_all();
        @(negedge clk);
        check("t2_done_once", 64'(cpu_done), 64'd0);
        check("t2_sb_drained", 64'(sb_q.size()), 64'd0);

        // ---- loader write, rdata untouched ----
        RUN = 1'b0; ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h4; ldr_wdata = 32'h1234;
        sb_q.push_back('{1'b1, 1'b0, 32'h0});
        @(negedge clk);                                   // N+1
        check("t3_gnt", 64'(ldr_gnt), 64'd1);
        check("t3_mem_we", 64'(mem_we), 64'd1);
        check("t3_mem_wdata", 64'(mem_wdata), 64'h1234);
        check("t3_mem_addr", 64'(mem_addr), 64'h4);
        @(negedge clk);                                   // N+2
        check("t3_mem_we_off", 64'(mem_we), 64'd0);
        check("t3_mem_en_off", 64'(mem_en), 64'd0);
        @(negedge clk);                                   // N+3
        #1;
        check("t3_done", 64'(ldr_done), 64'd1);
        check("t3_rdata_kept", 64'(rdata), 64'hDEAD_BEEF);
        drop_all();
        @(negedge clk);

        // ---- vector table ----
        foreach (vecs[i]) begin
            RUN       = vecs[i].run;
            cpu_req   = vecs[i].creq;  cpu_we = vecs[i].cwe;
            cpu_addr  = vecs[i].caddr; cpu_wdata = vecs[i].cwdata;
            ldr_req   = vecs[i].lreq;  ldr_we = vecs[i].lwe;
            ldr_addr  = vecs[i].laddr; ldr_wdata = vecs[i].lwdata;
            e.is_ldr  = vecs[i].exp_ldr;
            e.is_read = vecs[i].exp_ldr ? !vecs[i].lwe : !vecs[i].cwe;
            e.rdata   = vecs[i].exp_rdata;
            sb_q.push_back(e);
            drain($sformatf("vec%0d_complete", i), 20);
            @(negedge clk);
        end

        // ---- both requesting continuously, RUN=1: 4 cpu then 1 ldr ----
        RUN = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h04;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) sb_q.push_back('{1'b1, 1'b1, 32'h1234});
            else            sb_q.push_back('{1'b0, 1'b1, 32'h1111_2222});
        end
        drain("t4_fair_order", 60);
        @(negedge clk);

        // ---- request dropped and address changed mid-transaction ----
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        sb_q.push_back('{1'b0, 1'b1, 32'hA5A5_A5A5});
        @(negedge clk);                                   // N+1
        check("t6_gnt", 64'(cpu_gnt), 64'd1);
        cpu_req = 1'b0; cpu_addr = 32'h30;
        @(negedge clk);                                   // N+2
        check("t6_addr_latched", 64'(mem_addr), 64'h20);
        @(negedge clk);                                   // N+3
        #1;
        check("t6_done", 64'(cpu_done), 64'd1);
        check("t6_rdata", 64'(rdata), 64'hA5A5_A5A5);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cnt += int'(cpu_done) + int'(cpu_gnt) + int'(mem_en);
        end
        check("t6_no_reissue", 64'(cnt), 64'd0);

        // ---- MEM_LAT=3 instance: done 4 cycles after gnt ----
        c3_req = 1'b1; c3_addr = 32'h40;
        @(negedge clk);                                   // N+1
        check("t5_gnt", 64'(c3_gnt), 64'd1);
        check("t5_mem_en", 64'(mem3_en), 64'd1);
        check("t5_mem_addr", 64'(mem3_addr), 64'h40);
        check("t5_ldr_side", {62'd0, l3_gnt, mem3_we}, 64'd0);
        c3_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("t5_wait%0d", c), {62'd0, c3_done, mem3_en}, 64'd0);
        end
        @(negedge clk);                                   // N+5
        check("t5_done", 64'(c3_done), 64'd1);
        check("t5_rdata", 64'(rdata3), 64'hCAFE_0003);
        check("t5_stall", {62'd0, c3_stall, l3_done}, 64'd0);
        check("t5_wdata", 64'(mem3_wdata), 64'd0);
        @(negedge clk);
        check("t5_rdata_hold", 64'(rdata3), 64'hCAFE_0003);

        // ---- async reset during WAIT of a loader write ----
        RUN = 1'b0; ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h8; ldr_wdata = 32'h55;
        @(negedge clk);                                   // N+1
        check("t1_gnt", 64'(ldr_gnt), 64'd1);
        @(negedge clk);                                   // N+2, in WAIT
        RESET = 1'b1;
        #1;
        check("t1_mem_en", 64'(mem_en), 64'd0);
        check("t1_rdata", 64'(rdata), 64'd0);
        check("t1_mem_addr", 64'(mem_addr), 64'd0);
        check("t1_mem_wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        ldr_req = 1'b0;
        @(negedge clk);
        RESET = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cnt += int'(ldr_done) + int'(mem_en);
        end
        check("t1_no_done", 64'(cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
